// File: rtl/i2c_slave_regs_pkg.sv
// I2C register target: shared FSM state encodings
// and default address / deglitch-length constants.
package i2c_slave_regs_pkg;

  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h50;
  localparam int         FILT_LEN_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_deglitch.sv
// Input deglitcher: LEN-stage shift register.
// The output follows d_i only once every stage agrees.
// Ports: clk_i, rst_i (async, active-high), d_i raw
// input, q_o filtered output (resets to 1).
module i2c_deglitch #(
  parameter int LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [LEN-1:0] sh_q;
  logic           q_q;

  assign q_o = q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q <= '1;
      q_q  <= 1'b1;
    end else begin
      sh_q <= {sh_q[LEN-2:0], d_i};
      if (&sh_q) begin
        q_q <= 1'b1;
      end else if (~|sh_q) begin
        q_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target bridging bus transfers to a byte register
// port with an auto-incrementing 8-bit pointer.
// Ports: sys_clock, reset (async, active-high),
// sda_in/scl_in raw pins, sda_oe open-drain pull-down,
// reg_addr/reg_wdata/reg_wr/reg_rd/reg_rdata register
// port, selected (addressed since last START/STOP).
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF,
  parameter int         FILT_LEN   = FILT_LEN_DEF
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       selected
);

  logic sda_f, scl_f;
  logic sda_p_q, scl_p_q;
  logic scl_rise, scl_fall;
  logic start_ev, stop_ev;

  state_e     state_q;
  logic [3:0] bit_q;
  logic [7:0] rx_q, tx_q, ptr_q;
  logic       first_q, rw_q, mack_q;
  logic       load_q, inc_q;
  logic       sda_oe_q, sel_q, wr_q, rd_q;
  logic [7:0] addr_q, wdata_q;

  i2c_deglitch #(.LEN(FILT_LEN)) u_sda_filt (
    .clk_i (sys_clock),
    .rst_i (reset),
    .d_i   (sda_in),
    .q_o   (sda_f)
  );

  i2c_deglitch #(.LEN(FILT_LEN)) u_scl_filt (
    .clk_i (sys_clock),
    .rst_i (reset),
    .d_i   (scl_in),
    .q_o   (scl_f)
  );

  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  assign start_ev = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_ev  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  assign sda_oe    = sda_oe_q;
  assign selected  = sel_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      ptr_q    <= '0;
      first_q  <= 1'b0;
      rw_q     <= 1'b0;
      mack_q   <= 1'b0;
      load_q   <= 1'b0;
      inc_q    <= 1'b0;
      sda_oe_q <= 1'b0;
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sda_p_q  <= 1'b1;
      scl_p_q  <= 1'b1;
    end else begin
      sda_p_q <= sda_f;
      scl_p_q <= scl_f;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;

      // read data arrives one cycle after the strobe
      if (load_q) begin
        tx_q   <= reg_rdata;
        ptr_q  <= ptr_q + 8'd1;
        load_q <= 1'b0;
      end
      if (inc_q) begin
        ptr_q <= ptr_q + 8'd1;
        inc_q <= 1'b0;
      end

      if (start_ev) begin
        state_q  <= ST_ADDR;
        bit_q    <= '0;
        sda_oe_q <= 1'b0;
        sel_q    <= 1'b0;
        mack_q   <= 1'b0;
      end else if (stop_ev) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        sel_q    <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_WAIT_STOP: begin
            sda_oe_q <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise && bit_q < 4'd8) begin
              rx_q  <= {rx_q[6:0], sda_f};
              bit_q <= bit_q + 4'd1;
            end else if (scl_fall && bit_q == 4'd8) begin
              if (rx_q[7:1] == SLAVE_ADDR) begin
                sda_oe_q <= 1'b1;
                sel_q    <= 1'b1;
                rw_q     <= rx_q[0];
                state_q  <= ST_ADDR_ACK;
                if (rx_q[0]) begin
                  rd_q   <= 1'b1;
                  addr_q <= ptr_q;
                  load_q <= 1'b1;
                end
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                // present MSB as the ACK clock ends
                sda_oe_q <= ~tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
                bit_q    <= 4'd1;
                state_q  <= ST_RD_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                bit_q    <= '0;
                first_q  <= 1'b1;
                state_q  <= ST_WR_BYTE;
              end
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise && bit_q < 4'd8) begin
              rx_q  <= {rx_q[6:0], sda_f};
              bit_q <= bit_q + 4'd1;
            end else if (scl_fall && bit_q == 4'd8) begin
              sda_oe_q <= 1'b1;
              bit_q    <= '0;
              state_q  <= ST_WR_ACK;
              if (first_q) begin
                ptr_q   <= rx_q;
                first_q <= 1'b0;
              end else begin
                wr_q    <= 1'b1;
                addr_q  <= ptr_q;
                wdata_q <= rx_q;
                inc_q   <= 1'b1;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WR_BYTE;
            end
          end
          ST_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                mack_q   <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                sda_oe_q <= ~tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
                bit_q    <= bit_q + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                rd_q   <= 1'b1;
                addr_q <= ptr_q;
                load_q <= 1'b1;
                mack_q <= 1'b1;
              end else begin
                state_q <= ST_WAIT_STOP;
              end
            end else if (scl_fall && mack_q) begin
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
              bit_q    <= 4'd1;
              mack_q   <= 1'b0;
              state_q  <= ST_RD_BYTE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Self-checking bench for i2c_slave_regs: bit-banged
// master, register file, and pointer/memory model.
module tb_i2c_slave_regs;

  localparam int Q = 10;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] ab;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         n;
    bit         ack;
    logic [7:0] wa0;
    logic [7:0] wa1;
    logic [7:0] nxt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_oe, reg_wr, reg_rd, selected;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       sda_bus;

  logic [7:0] rf [256];
  logic [7:0] mm [256];
  logic [7:0] mptr;

  wr_t        wr_log[$];
  wr_t        exp_wr[$];
  logic [7:0] rd_log[$];
  logic [7:0] exp_rd[$];

  int checks = 0;
  int errors = 0;
  bit glitch = 1'b0;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = rf[reg_addr];

  always #5 clk = ~clk;

  i2c_slave_regs dut (
    .sys_clock (clk),
    .reset     (rst),
    .sda_in    (sda_bus),
    .scl_in    (scl_m),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .selected  (selected)
  );

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_log.push_back(wr_t'({reg_addr, reg_wdata}));
      rf[reg_addr] = reg_wdata;
    end
    if (reg_rd) rd_log.push_back(reg_addr);
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input bit b);
    sda_m = b;
    wq(Q / 2);
    if (glitch) begin scl_m = 1'b1; wq(1); scl_m = 1'b0; end
    wq(Q / 2);
    scl_m = 1'b1;
    wq(Q);
    if (glitch) begin scl_m = 1'b0; wq(1); scl_m = 1'b1; end
    wq(Q);
    scl_m = 1'b0;
    wq(Q);
  endtask

  task automatic recv_bit(output bit b);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    b = sda_bus;  wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output bit ack);
    bit nb;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(nb);
    ack = ~nb;
  endtask

  task automatic rd_byte(output logic [7:0] d, input bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    mm[a] = d;
    exp_wr.push_back(wr_t'({a, d}));
  endtask

  task automatic cmp_logs(input string nm);
    chk({nm, "_wr_n"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
      chk({nm, "_wr_a"}, wr_log[i].a, exp_wr[i].a);
      chk({nm, "_wr_d"}, wr_log[i].d, exp_wr[i].d);
    end
    chk({nm, "_rd_n"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) begin
      chk({nm, "_rd_a"}, rd_log[i], exp_rd[i]);
    end
    wr_log.delete();
    exp_wr.delete();
    rd_log.delete();
    exp_rd.delete();
  endtask

  initial begin
    vec_t       vt [4];
    vec_t       v;
    bit         a;
    logic [7:0] d, p, dv;
    logic [6:0] ba;
    int         n, kind;
    bit         setp;

    for (int i = 0; i < 256; i++) begin
      rf[i] = 8'($urandom);
      mm[i] = rf[i];
    end
    rf[8'h20] = 8'hC3; mm[8'h20] = 8'hC3;
    rf[8'h21] = 8'h7E; mm[8'h21] = 8'h7E;
    rf[8'h40] = 8'h00; mm[8'h40] = 8'h00;
    mptr = 8'h00;

    vt[0] = '{8'hA0, 8'h10, 8'hA5, 8'h3C, 2, 1'b1,
              8'h10, 8'h11, 8'h12};
    vt[1] = '{8'hA0, 8'hFF, 8'h11, 8'h22, 2, 1'b1,
              8'hFF, 8'h00, 8'h01};
    vt[2] = '{8'hA4, 8'h33, 8'h44, 8'h55, 2, 1'b0,
              8'h00, 8'h00, 8'h00};
    vt[3] = '{8'hA0, 8'h7F, 8'h5A, 8'h00, 1, 1'b1,
              8'h7F, 8'h00, 8'h80};

    // reset state
    wq(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr", reg_wr, 0);
    chk("rst_rd", reg_rd, 0);
    chk("rst_sel", selected, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    rst = 1'b0;
    wq(Q);

    // table-driven write transfers
    for (int i = 0; i < 4; i++) begin
      v = vt[i];
      i2c_start;
      wr_byte(v.ab, a);
      chk("vec_addr_ack", a, v.ack);
      chk("vec_sel_on", selected, v.ack);
      wr_byte(v.ptr, a);
      chk("vec_ptr_ack", a, v.ack);
      wr_byte(v.d0, a);
      chk("vec_d0_ack", a, v.ack);
      if (v.n > 1) begin
        wr_byte(v.d1, a);
        chk("vec_d1_ack", a, v.ack);
      end
      i2c_stop;
      chk("vec_sel_off", selected, 0);
      if (v.ack) begin
        m_write(v.wa0, v.d0);
        if (v.n > 1) m_write(v.wa1, v.d1);
      end
      cmp_logs("vec");
      if (v.ack) begin
        // current-address read exposes the pointer
        i2c_start;
        wr_byte(8'hA1, a);
        chk("cur_ack", a, 1);
        rd_byte(d, 1'b0);
        i2c_stop;
        exp_rd.push_back(v.nxt);
        chk("cur_data", d, mm[v.nxt]);
        cmp_logs("cur");
        mptr = 8'(v.nxt + 8'd1);
      end
    end

    // pointer write, repeated start, two-byte read
    i2c_start;
    wr_byte(8'hA0, a); chk("rs_addr_ack", a, 1);
    wr_byte(8'h20, a); chk("rs_ptr_ack", a, 1);
    i2c_start;
    wr_byte(8'hA1, a); chk("rs_rd_ack", a, 1);
    rd_byte(d, 1'b1);  chk("rs_rd0", d, 8'hC3);
    rd_byte(d, 1'b0);  chk("rs_rd1", d, 8'h7E);
    chk("rs_nack_rel", sda_oe, 0);
    i2c_stop;
    exp_rd.push_back(8'h20);
    exp_rd.push_back(8'h21);
    cmp_logs("rs");
    mptr = 8'h22;

    // SCL glitches in every bit
    glitch = 1'b1;
    i2c_start;
    wr_byte(8'hA0, a); chk("gl_addr_ack", a, 1);
    wr_byte(8'h05, a); chk("gl_ptr_ack", a, 1);
    wr_byte(8'h99, a); chk("gl_d_ack", a, 1);
    glitch = 1'b0;
    i2c_stop;
    m_write(8'h05, 8'h99);
    cmp_logs("gl");
    mptr = 8'h06;

    // reset while driving a read bit
    i2c_start;
    wr_byte(8'hA0, a); chk("rb_addr_ack", a, 1);
    wr_byte(8'h40, a); chk("rb_ptr_ack", a, 1);
    i2c_start;
    wr_byte(8'hA1, a); chk("rb_rd_ack", a, 1);
    chk("rb_oe_drive", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("rb_oe_async", sda_oe, 0);
    chk("rb_sel", selected, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wq(4);
    rst = 1'b0;
    wq(Q);
    exp_rd.push_back(8'h40);
    cmp_logs("rb");
    i2c_start;
    wr_byte(8'hA0, a); chk("pr_addr_ack", a, 1);
    wr_byte(8'h00, a); chk("pr_ptr_ack", a, 1);
    wr_byte(8'h01, a); chk("pr_d_ack", a, 1);
    i2c_stop;
    m_write(8'h00, 8'h01);
    cmp_logs("pr");
    mptr = 8'h01;

    // randomized transfers against the model
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          do ba = 7'($urandom); while (ba == 7'h50);
          i2c_start;
          wr_byte({ba, 1'($urandom)}, a);
          chk("rnd_bad_ack", a, 0);
          wr_byte(8'($urandom), a);
          chk("rnd_bad_d", a, 0);
          i2c_stop;
          chk("rnd_bad_sel", selected, 0);
          cmp_logs("rnd_bad");
        end
        3: begin
          setp = 1'($urandom_range(0, 1));
          p = setp ? 8'($urandom) : mptr;
          n = $urandom_range(1, 4);
          i2c_start;
          if (setp) begin
            wr_byte(8'hA0, a); chk("rnd_rp_ack", a, 1);
            wr_byte(p, a);     chk("rnd_rpp_ack", a, 1);
            i2c_start;
          end
          wr_byte(8'hA1, a);
          chk("rnd_ra_ack", a, 1);
          for (int k = 0; k < n; k++) begin
            rd_byte(d, k != n - 1);
            chk("rnd_rd", d, mm[8'(p + k)]);
            exp_rd.push_back(8'(p + k));
          end
          i2c_stop;
          cmp_logs("rnd_rd");
          mptr = 8'(p + n);
        end
        default: begin
          p = 8'($urandom);
          n = $urandom_range(1, 4);
          i2c_start;
          wr_byte(8'hA0, a); chk("rnd_wa_ack", a, 1);
          wr_byte(p, a);     chk("rnd_wp_ack", a, 1);
          for (int k = 0; k < n; k++) begin
            dv = 8'($urandom);
            wr_byte(dv, a);
            chk("rnd_wd_ack", a, 1);
            m_write(8'(p + k), dv);
          end
          i2c_stop;
          cmp_logs("rnd_wr");
          mptr = 8'(p + n);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, is the 7-bit I2C address this target answers to.
REQ-002 Parameter FILT_LEN, default 4, is the input deglitch shift-register length in sys_clock cycles.
REQ-003 sys_clock  input  1  sole clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sda_in  input  1  raw SDA pin feedback.
REQ-006 scl_in  input  1  raw SCL pin feedback.
REQ-007 sda_oe  output  1  1 = pull SDA low; 0 = release. The pad is open-drain and driven data is always 0.
REQ-008 reg_addr  output  8  register pointer presented with reg_wr and reg_rd.
REQ-009 reg_wdata  output  8  write data, valid while reg_wr=1.
REQ-010 reg_wr  output  1  one-cycle register write strobe.
REQ-011 reg_rd  output  1  one-cycle register read strobe.
REQ-012 reg_rdata  input  8  read data, sampled exactly 1 cycle after reg_rd.
REQ-013 selected  output  1  1 from the address-match ACK until the next START or STOP.

Function
REQ-014 Each of SDA and SCL shall pass through its own FILT_LEN-stage shift register. The filtered value shall change only when all stages agree, and hold otherwise.
REQ-015 Filtered-signal events, each a one-cycle pulse:
- scl_rise: 0->1 on filtered SCL.
- scl_fall: 1->0 on filtered SCL.
- START: filtered SDA 1->0 while filtered SCL=1.
- STOP: filtered SDA 0->1 while filtered SCL=1.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-017 START in any state shall go to ADDR, clear the bit count and set sda_oe=0 in the same cycle. This covers repeated start.
REQ-018 STOP in any state shall go to IDLE with sda_oe=0 and selected=0. The pointer is retained.
REQ-019 Data and address bits shall be sampled on scl_rise, MSB first. sda_oe shall change only on scl_fall, START or STOP.
REQ-020 ADDR: after 8 bits, on the next scl_fall:
- address match -> sda_oe=1, selected=1, go to ADDR_ACK;
- mismatch -> go to WAIT_STOP with SDA released.
REQ-021 ADDR_ACK, R/W=0: on the scl_fall ending the ACK, release SDA and go to WR_BYTE. The first byte after the address is the pointer.
REQ-022 ADDR_ACK, R/W=1: reg_rd pulses with reg_addr=pointer on the cycle ACK is asserted. reg_rdata is loaded into the TX shift register on the next cycle, and the pointer increments. On the scl_fall ending the ACK, sda_oe shall equal the inverse of the MSB, and the state goes to RD_BYTE.
REQ-023 WR_BYTE: after 8 bits, on the next scl_fall, drive ACK and go to WR_ACK.
- First byte of the transfer: load the pointer.
- Later bytes: pulse reg_wr for one cycle with reg_addr=pointer and reg_wdata=byte, then increment the pointer on the following cycle.
REQ-024 WR_ACK: on scl_fall, release SDA and return to WR_BYTE.
REQ-025 RD_BYTE: on each scl_fall, shift the next bit out. On the scl_fall after bit 8, release SDA and go to RD_ACK.
REQ-026 RD_ACK: sample the master acknowledge on scl_rise.
- 0 (ACK): pulse reg_rd, load reg_rdata, increment the pointer, drive its MSB on the next scl_fall, then go to RD_BYTE.
- 1 (NACK): go to WAIT_STOP.
REQ-027 The pointer is 8 bits and wraps 8'hFF -> 8'h00 on increment.
REQ-028 WAIT_STOP and IDLE keep sda_oe=0 and ignore SCL edges.
REQ-029 The block shall never drive SCL; clock stretching is not supported.

Reset
REQ-030 On reset:
- sda_oe=0, reg_wr=0, reg_rd=0, selected=0;
- reg_addr=0, reg_wdata=0;
- state=IDLE, pointer=0, bit count=0;
- filter stages and filtered outputs all 1.
REQ-031 Reset asserted mid-transfer shall release SDA immediately (asynchronously).

Structure
REQ-032 A shared package shall hold the state encodings and the default SLAVE_ADDR and FILT_LEN constants.
REQ-033 The deglitch filter shall be the sub-module i2c_deglitch, instantiated once for SDA and once for SCL.
REQ-034 Pad (SB_IO) instantiation stays outside this block.

Verification
REQ-035 Write 50h, pointer 10h, data A5h, 3Ch, STOP -> ACK on all 4 bytes; reg_wr@10h=A5h, then reg_wr@11h=3Ch; final pointer 12h.
REQ-036 Write 50h, pointer FFh, data 11h, 22h -> writes land at FFh then 00h (wrap).
REQ-037 Write 50h with pointer 20h, repeated START, read 51h, master ACK then NACK, STOP -> reg_rd@20h and @21h; reg_rdata C3h and 7Eh appear on SDA MSB-first; SDA released after the NACK.
REQ-038 Address 52h -> no ACK (SDA high at the 9th clock), selected stays 0, no strobes, bus ignored until STOP.
REQ-039 1-cycle glitches on SCL during a write of 50h/05h/99h -> no extra bits sampled; reg_wr@05h=99h still correct.
REQ-040 Reset asserted in RD_BYTE while sda_oe=1 -> sda_oe=0 in the same cycle; the next write of 50h/00h/01h succeeds.
